// File: rtl/audio_clip_sequencer.sv
// audio_clip_sequencer: plays one clip of 16-bit PCM from the sample ROM at
// the 44.1 kHz cadence and hands each sample to the serialiser via valid/ready.
module audio_clip_sequencer #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 16,
  parameter int SAMPLE_DIV = 2268,
  parameter int ROM_LAT    = 2
) (
  input  logic              Clock_100MHz,
  input  logic              Clear,
  input  logic              Play,
  input  logic              Stop,
  input  logic              Pause,
  input  logic              Loop,
  input  logic [ADDR_W-1:0] Clip_Start,
  input  logic [ADDR_W-1:0] Clip_End,
  output logic [ADDR_W-1:0] ROM_Addr,
  output logic              ROM_En,
  input  logic [DATA_W-1:0] ROM_Data,
  output logic [DATA_W-1:0] Sample_Data,
  output logic              Sample_Valid,
  input  logic              Sample_Ready,
  output logic              Busy,
  output logic              Done,
  output logic              Overrun,
  output logic              AUD_SD
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {IDLE, WAIT, FETCH, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, start_q, start_d, end_q, end_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                rom_en_q, rom_en_d;
  logic [ROM_LAT-1:0]  rd_pipe_q, rd_pipe_d;
  logic [DATA_W-1:0]   sdata_q, sdata_d;
  logic                svalid_q, svalid_d;
  logic                busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;

  // Transient helpers for the fetch-issue path.
  logic [ROM_LAT:0]    pipe_shift;
  logic                cap, issue;
  logic [ADDR_W-1:0]   iss_addr, iss_start, iss_end;

  // Next-state: handshake/capture, cadence, fetch issue, then Play and Stop overrides.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    addr_d     = addr_q;
    start_d    = start_q;
    end_d      = end_q;
    last_d     = last_q;
    rom_addr_d = rom_addr_q;
    rom_en_d   = 1'b0;
    sdata_d    = sdata_q;
    svalid_d   = svalid_q;
    ovr_d      = ovr_q;
    done_d     = 1'b0;
    iss_addr   = addr_q;
    iss_start  = start_q;
    iss_end    = end_q;
    issue      = 1'b0;

    // rd_pipe tracks an outstanding read; its top bit marks the capture edge.
    pipe_shift = {rd_pipe_q, rom_en_q};
    rd_pipe_d  = pipe_shift[ROM_LAT-1:0];
    cap        = rd_pipe_q[ROM_LAT-1];

    if (svalid_q && Sample_Ready) svalid_d = 1'b0;
    if (cap) begin
      if (!svalid_q || Sample_Ready) begin
        sdata_d  = ROM_Data;
        svalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    case (state_q)
      WAIT: if (!Pause) begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          issue   = 1'b1;
          state_d = FETCH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      FETCH: if (!Pause) begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        // Leave once the read has been captured (or if it already was while paused).
        if (cap || (rd_pipe_q == '0 && !rom_en_q))
          state_d = last_q ? DRAIN : WAIT;
      end
      DRAIN: if (!Pause && !svalid_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: ;
    endcase

    if (Stop) begin
      state_d   = IDLE;
      svalid_d  = 1'b0;
      rd_pipe_d = '0;
      issue     = 1'b0;
    end else if (Play && (Clip_Start <= Clip_End)) begin
      start_d   = Clip_Start;
      end_d     = Clip_End;
      iss_addr  = Clip_Start;
      iss_start = Clip_Start;
      iss_end   = Clip_End;
      div_d     = '0;
      ovr_d     = 1'b0;
      svalid_d  = 1'b0;
      rd_pipe_d = '0;
      done_d    = 1'b0;
      state_d   = FETCH;
      issue     = 1'b1;
    end

    // Fetch issue: strobe the ROM and advance, wrapping or ending at the clip end.
    if (issue) begin
      rom_en_d   = 1'b1;
      rom_addr_d = iss_addr;
      last_d     = 1'b0;
      if (iss_addr == iss_end) begin
        if (Loop) addr_d = iss_start;
        else begin
          addr_d = iss_addr;
          last_d = 1'b1;
        end
      end else begin
        addr_d = iss_addr + 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; Clear drops everything immediately.
  always_ff @(posedge Clock_100MHz or posedge Clear) begin
    if (Clear) begin
      state_q    <= IDLE;
      div_q      <= '0;
      addr_q     <= '0;
      start_q    <= '0;
      end_q      <= '0;
      last_q     <= 1'b0;
      rom_addr_q <= '0;
      rom_en_q   <= 1'b0;
      rd_pipe_q  <= '0;
      sdata_q    <= '0;
      svalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      addr_q     <= addr_d;
      start_q    <= start_d;
      end_q      <= end_d;
      last_q     <= last_d;
      rom_addr_q <= rom_addr_d;
      rom_en_q   <= rom_en_d;
      rd_pipe_q  <= rd_pipe_d;
      sdata_q    <= sdata_d;
      svalid_q   <= svalid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
    end
  end

  assign ROM_Addr     = rom_addr_q;
  assign ROM_En       = rom_en_q;
  assign Sample_Data  = sdata_q;
  assign Sample_Valid = svalid_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Overrun      = ovr_q;
  assign AUD_SD       = busy_q;

endmodule

// File: tb/tb_audio_clip_sequencer.sv
// Bench for audio_clip_sequencer: ROM model returns its address, a scoreboard
// queue holds the samples the serialiser should receive in order.
module tb_audio_clip_sequencer;
  localparam int ADDR_W = 19, DATA_W = 16, SAMPLE_DIV = 8, ROM_LAT = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic Play = 0, Stop = 0, Pause = 0, Loop = 0, Sample_Ready = 1;
  logic [ADDR_W-1:0] Clip_Start = '0, Clip_End = '0, ROM_Addr;
  logic ROM_En, Sample_Valid, Busy, Done, Overrun, AUD_SD;
  logic [DATA_W-1:0] ROM_Data, Sample_Data;

  audio_clip_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SAMPLE_DIV(SAMPLE_DIV), .ROM_LAT(ROM_LAT)) dut (
    .Clock_100MHz(clk), .Clear(rst), .Play(Play), .Stop(Stop), .Pause(Pause), .Loop(Loop),
    .Clip_Start(Clip_Start), .Clip_End(Clip_End), .ROM_Addr(ROM_Addr), .ROM_En(ROM_En),
    .ROM_Data(ROM_Data), .Sample_Data(Sample_Data), .Sample_Valid(Sample_Valid),
    .Sample_Ready(Sample_Ready), .Busy(Busy), .Done(Done), .Overrun(Overrun), .AUD_SD(AUD_SD));

  always #5 clk = ~clk;

  // ROM model: ROM_LAT-deep register pipeline returning the address as data.
  logic [ADDR_W-1:0] rom_s1, rom_s2;
  always @(posedge clk) begin
    rom_s1 <= ROM_Addr;
    rom_s2 <= rom_s1;
  end
  assign ROM_Data = rom_s2[DATA_W-1:0];

  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, hs_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];
  int en_t[$];

  always @(posedge clk) cyc++;

  // Monitor: scoreboard on handshakes, ROM_En timestamps, Done bookkeeping.
  always @(negedge clk) begin
    if (!rst) begin
      if (ROM_En) en_t.push_back(cyc);
      if (Sample_Valid && Sample_Ready) begin
        logic [DATA_W-1:0] e;
        checks++; hs_cnt++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL sample_unexpected got %0d, none expected", Sample_Data);
        end else begin
          e = exp_q.pop_front();
          if (Sample_Data !== e) begin
            errors++; $display("FAIL sample_data got %0d expected %0d", Sample_Data, e);
          end
        end
      end
      if (Done) begin
        done_cnt++; checks++;
        if (Busy !== 1'b0 || AUD_SD !== 1'b0) begin
          errors++; $display("FAIL done_busy Busy=%b AUD_SD=%b expected 0 with Done", Busy, AUD_SD);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic play(input int s, input int e);
    Clip_Start = ADDR_W'(s); Clip_End = ADDR_W'(e); Play = 1;
    tick();
    Play = 0;
  endtask

  task automatic wait_done(input int max, input string name);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < max) begin tick(); n++; end
    checks++;
    if (done_cnt == d0) begin errors++; $display("FAIL %s_timeout no Done within %0d cycles", name, max); end
  endtask

  task automatic check_gaps(input string name, input int want[$]);
    checks++;
    if (en_t.size() != want.size() + 1) begin
      errors++; $display("FAIL %s_en_count got %0d expected %0d", name, en_t.size(), want.size() + 1);
    end else
      for (int i = 0; i < want.size(); i++) begin
        checks++;
        if (en_t[i+1] - en_t[i] != want[i]) begin
          errors++; $display("FAIL %s_gap%0d got %0d expected %0d", name, i, en_t[i+1] - en_t[i], want[i]);
        end
      end
  endtask

  task automatic check_drained(input string name, input int hs_want, input int hs0);
    checks++;
    if (exp_q.size() != 0 || hs_cnt - hs0 != hs_want) begin
      errors++; $display("FAIL %s_drain left=%0d handshakes=%0d expected 0/%0d", name, exp_q.size(), hs_cnt - hs0, hs_want);
    end
  endtask

  task automatic test_reset();
    int d0;
    #1; checks++;
    if ({ROM_Addr, ROM_En, Sample_Data, Sample_Valid, Busy, Done, Overrun, AUD_SD} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h expected 0", {ROM_Addr, ROM_En, Sample_Data, Sample_Valid, Busy, Done, Overrun, AUD_SD});
    end
    tick(); rst = 0; tick();
    Sample_Ready = 0;
    play(10, 12);
    repeat (5) tick();
    checks++;
    if (Sample_Valid !== 1'b1 || Busy !== 1'b1) begin
      errors++; $display("FAIL reset_pre valid=%b busy=%b expected 1/1", Sample_Valid, Busy);
    end
    #2 rst = 1; #1;
    checks++;
    if ({ROM_Addr, ROM_En, Sample_Data, Sample_Valid, Busy, Done, Overrun, AUD_SD} !== '0) begin
      errors++; $display("FAIL reset_async got %h expected 0", {ROM_Addr, ROM_En, Sample_Data, Sample_Valid, Busy, Done, Overrun, AUD_SD});
    end
    tick(); rst = 0; Sample_Ready = 1; d0 = done_cnt;
    repeat (20) tick();
    checks++;
    if (done_cnt != d0 || Busy !== 1'b0 || Sample_Valid !== 1'b0) begin
      errors++; $display("FAIL reset_release done=%0d busy=%b valid=%b expected %0d/0/0", done_cnt, Busy, Sample_Valid, d0);
    end
  endtask

  task automatic test_single_clip();
    int d0 = done_cnt, h0 = hs_cnt;
    exp_q = '{16'd10, 16'd11, 16'd12};
    en_t.delete(); Loop = 0;
    play(10, 12);
    checks++;
    if (ROM_En !== 1'b1 || ROM_Addr !== 19'd10 || AUD_SD !== 1'b1) begin
      errors++; $display("FAIL single_first en=%b addr=%0d sd=%b expected 1/10/1", ROM_En, ROM_Addr, AUD_SD);
    end
    wait_done(100, "single");
    tick();
    check_gaps("single", '{8, 8});
    check_drained("single", 3, h0);
    checks++;
    if (done_cnt != d0 + 1 || AUD_SD !== 1'b0) begin
      errors++; $display("FAIL single_done count=%0d sd=%b expected %0d/0", done_cnt - d0, AUD_SD, 1);
    end
  endtask

  task automatic test_loop();
    int n = 0, k = 0, h0 = hs_cnt;
    exp_q = '{16'd10, 16'd11, 16'd10, 16'd11, 16'd10, 16'd11};
    Loop = 1;
    play(10, 11);
    n = 1;
    while (n < 4 && k < 100) begin tick(); k++; if (ROM_En) n++; end
    Loop = 0;
    wait_done(100, "loop");
    tick();
    check_drained("loop", 6, h0);
  endtask

  task automatic test_pause_stop();
    int h0 = hs_cnt, d0;
    exp_q = '{16'd10, 16'd11, 16'd12};
    en_t.delete();
    play(10, 12);
    repeat (3) tick();
    Pause = 1; repeat (5) tick(); Pause = 0;
    wait_done(100, "pause");
    tick();
    check_gaps("pause", '{13, 8});
    check_drained("pause", 3, h0);
    d0 = done_cnt; h0 = hs_cnt;
    play(10, 12);
    Stop = 1; tick(); Stop = 0;
    checks++;
    if (Busy !== 1'b0 || Sample_Valid !== 1'b0 || ROM_En !== 1'b0) begin
      errors++; $display("FAIL stop_fetch busy=%b valid=%b en=%b expected 0/0/0", Busy, Sample_Valid, ROM_En);
    end
    repeat (20) tick();
    checks++;
    if (done_cnt != d0 || hs_cnt != h0) begin
      errors++; $display("FAIL stop_quiet done=%0d hs=%0d expected %0d/%0d", done_cnt, hs_cnt, d0, h0);
    end
  endtask

  task automatic test_backpressure();
    int h0 = hs_cnt;
    exp_q = '{16'd10, 16'd12};
    Sample_Ready = 0;
    play(10, 12);
    repeat (12) tick();
    checks++;
    if (Overrun !== 1'b1 || Sample_Valid !== 1'b1 || Sample_Data !== 16'd10) begin
      errors++; $display("FAIL bp_hold ovr=%b valid=%b data=%0d expected 1/1/10", Overrun, Sample_Valid, Sample_Data);
    end
    repeat (2) tick();
    Sample_Ready = 1;
    wait_done(100, "bp");
    tick();
    check_drained("bp", 2, h0);
    checks++;
    if (Overrun !== 1'b1) begin errors++; $display("FAIL bp_sticky ovr=%b expected 1", Overrun); end
  endtask

  task automatic test_edge_commands();
    int d0, h0;
    play(20, 19);
    checks++;
    if (Busy !== 1'b0 || ROM_En !== 1'b0 || Overrun !== 1'b1) begin
      errors++; $display("FAIL bad_range busy=%b en=%b ovr=%b expected 0/0/1", Busy, ROM_En, Overrun);
    end
    Stop = 1; play(10, 12); Stop = 0;
    checks++;
    if (Busy !== 1'b0 || ROM_En !== 1'b0) begin
      errors++; $display("FAIL play_stop busy=%b en=%b expected 0/0", Busy, ROM_En);
    end
    repeat (3) tick();
    d0 = done_cnt; h0 = hs_cnt;
    exp_q = '{16'd10};
    play(10, 12);
    checks++;
    if (Overrun !== 1'b0) begin errors++; $display("FAIL play_clears_ovr ovr=%b expected 0", Overrun); end
    repeat (9) tick();
    exp_q.push_back(16'd30); exp_q.push_back(16'd31);
    play(30, 31);
    checks++;
    if (ROM_En !== 1'b1 || ROM_Addr !== 19'd30) begin
      errors++; $display("FAIL restart en=%b addr=%0d expected 1/30", ROM_En, ROM_Addr);
    end
    wait_done(100, "restart");
    tick();
    check_drained("restart", 3, h0);
    checks++;
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL restart_done count=%0d expected 1", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_single_clip();
    test_loop();
    test_pause_stop();
    test_backpressure();
    test_edge_commands();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/audio_clip_sequencer.md
# audio_clip_sequencer

Playback controller that sequences 16-bit PCM reads from the audio sample Block ROM and hands each sample to the PWM/bit-serialiser stage over a valid/ready handshake. It generates the 44.1 kHz sample cadence from the 100 MHz system clock and plays one clip, defined by a start/end address pair, per Play command. It supports stop, pause and loop, and drives the amplifier shutdown signal. The block sits between the top-level user controls and the Block ROM / serialiser pair.

## Interface
- ADDR_W, 19, ROM address width
- DATA_W, 16, sample width
- SAMPLE_DIV, 2268, system-clock cycles per sample period (100 MHz / 44.1 kHz, rounded); must be > ROM_LAT + 2
- ROM_LAT, 2, ROM read latency in cycles from ROM_En edge to valid ROM_Data; range 1..4

- Clock_100MHz  input  1  system clock, all logic on rising edge
- Clear  input  1  asynchronous, active-high reset
- Play  input  1  one-cycle pulse: start or restart the clip given by Clip_Start/Clip_End
- Stop  input  1  one-cycle pulse: abort playback
- Pause  input  1  level: freeze cadence and address while high
- Loop  input  1  level, sampled at each end-of-clip: wrap to start instead of finishing
- Clip_Start  input  ADDR_W  first sample address, latched on accepted Play
- Clip_End  input  ADDR_W  last sample address (inclusive), latched on accepted Play
- ROM_Addr  output  ADDR_W  ROM read address
- ROM_En  output  1  one-cycle read strobe
- ROM_Data  input  DATA_W  ROM read data
- Sample_Data  output  DATA_W  sample to serialiser
- Sample_Valid  output  1  Sample_Data valid
- Sample_Ready  input  1  serialiser accepts sample when high with Sample_Valid
- Busy  output  1  high in any state except IDLE
- Done  output  1  one-cycle pulse on natural end of a non-looping clip
- Overrun  output  1  sticky: a fetched sample was dropped
- AUD_SD  output  1  amplifier enable, equals Busy

## Operation
- States: IDLE, WAIT (counting to next tick), FETCH (ROM_LAT-cycle latency countdown), DRAIN (last sample pending handoff).
- Reset: state IDLE; ROM_Addr 0, ROM_En 0, Sample_Data 0, Sample_Valid 0, Busy 0, Done 0, Overrun 0, AUD_SD 0; divider 0.
- Play accepted when Clip_Start <= Clip_End: latch Start/End, address <= Clip_Start, divider <= 0, Overrun cleared, Sample_Valid cleared, go FETCH. Accepted in any state (restart). Play with Clip_Start > Clip_End ignored, no state change.
- Stop in any state: go IDLE next edge, Sample_Valid cleared, ROM_En 0, no Done. Stop and Play same cycle: Stop wins.
- FETCH entry issues ROM_En=1 for one cycle with ROM_Addr = current address; ROM_Data captured ROM_LAT edges later, then state WAIT (or DRAIN if that was Clip_End and Loop low).
- Capture: if Sample_Valid low, or high and Sample_Ready high that cycle, load Sample_Data and set Sample_Valid; otherwise drop sample and set Overrun.
- Handshake: Sample_Valid falls on the edge where Sample_Valid & Sample_Ready, unless a new capture occurs that edge.
- Address advance at fetch issue: address == latched End -> Loop high: address <= Start; Loop low: last fetch. Else address + 1. Width ADDR_W, no wrap beyond End.
- Divider counts 0..SAMPLE_DIV-1 continuously across WAIT/FETCH; at SAMPLE_DIV-1 (tick) next fetch issues. Pause high: divider, address and state frozen; in-flight ROM capture still completes; handshake still operates.
- DRAIN: wait until Sample_Valid low (or Stop); then IDLE with Done=1 for one cycle.

## Timing
- Play at edge E0 -> ROM_En high in cycle after E0 with ROM_Addr = Clip_Start; subsequent ROM_En pulses exactly SAMPLE_DIV cycles apart while Pause low.
- Sample_Valid rises ROM_LAT edges after the edge that sampled ROM_En high.
- Pause held N cycles stretches the gap between two ROM_En pulses by exactly N.
- Done occurs no earlier than one cycle after the last sample handshake; Busy/AUD_SD fall on the same edge Done rises.
- Clear mid-operation: all outputs to reset values immediately (asynchronous), pending sample discarded.

## Test plan
- Reset: assert Clear mid-playback -> all outputs 0 same cycle, state IDLE, no Done on release.
- Single clip: SAMPLE_DIV=8, ROM_LAT=2, ROM model returns address, Ready=1, Start=10, End=12, Loop=0 -> Sample_Data 10,11,12, ROM_En 8 cycles apart, one Done pulse, AUD_SD 1->0.
- Loop: Start=10, End=11, Loop=1 -> sequence 10,11,10,11...; drop Loop -> finishes after next 11 with Done.
- Pause/Stop: Pause 5 cycles between fetches -> gap 13; Stop during FETCH -> IDLE next edge, Sample_Valid 0, no Done.
- Backpressure: Ready=0 for 2 sample periods -> first sample held, second dropped, Overrun=1 until next Play.
- Edge commands: Play with Start=20, End=19 -> ignored; Play+Stop same cycle -> IDLE; Play while busy -> restart at new Clip_Start.
